// File: rtl/text_console.sv
// ----------------------------------------------------------------------------
// text_console
//   Upstream stage of the textmode renderer. Accepts a stream of Unicode code
//   points with colour indices and writes them as tram words at the cursor.
//   Handles CR, LF, BS, line wrap and hardware scrolling. Scrolling moves
//   scroll_offs one row forward and blanks the row that becomes the new bottom.
//
//   Tram word layout: [WORD-1 -: CIDXW] = bg, next CIDXW = fg, [20:0] = ucp,
//   all other bits zero.
//
//   Optional feature macro: TEXT_CONSOLE_CLS_EN
//     defined   : ucp 0x0C clears the whole tram and homes cursor and scroll.
//     undefined : ucp 0x0C is consumed with no effect.
//
// Ports
//   clk_sys      in   system clock
//   rst_sys_n    in   asynchronous active-low reset
//   cmd_valid    in   char command valid
//   cmd_ready    out  console can accept a command (registered, high in idle)
//   cmd_ucp      in   Unicode code point (21 bits)
//   cmd_fg       in   foreground colour index
//   cmd_bg       in   background colour index
//   tram_we      out  tram write enable, one word per cycle
//   tram_addr    out  tram write address
//   tram_din     out  tram write data
//   scroll_offs  out  tram address of the top display row
//   cur_x        out  cursor column
//   cur_y        out  cursor row relative to screen top
//   busy         out  row clear or screen clear in progress
// ----------------------------------------------------------------------------
module text_console #(
    parameter int unsigned WORD      = 32,
    parameter int unsigned ADDRW     = 14,
    parameter int unsigned CIDXW     = 4,
    parameter int unsigned TRAM_HRES = 84,
    parameter int unsigned TRAM_VRES = 24
) (
    input  logic             clk_sys,
    input  logic             rst_sys_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [20:0]      cmd_ucp,
    input  logic [CIDXW-1:0] cmd_fg,
    input  logic [CIDXW-1:0] cmd_bg,
    output logic             tram_we,
    output logic [ADDRW-1:0] tram_addr,
    output logic [WORD-1:0]  tram_din,
    output logic [ADDRW-1:0] scroll_offs,
    output logic [ADDRW-1:0] cur_x,
    output logic [ADDRW-1:0] cur_y,
    output logic             busy
);

    localparam int unsigned TOTAL = TRAM_HRES * TRAM_VRES;

    localparam logic [ADDRW-1:0] HRES_W   = ADDRW'(TRAM_HRES);
    localparam logic [ADDRW-1:0] HRES_M1  = ADDRW'(TRAM_HRES - 1);
    localparam logic [ADDRW-1:0] VRES_M1  = ADDRW'(TRAM_VRES - 1);
    localparam logic [ADDRW-1:0] TOTAL_M1 = ADDRW'(TOTAL - 1);
    localparam logic [ADDRW:0]   TOTAL_X  = (ADDRW + 1)'(TOTAL);

    localparam logic [20:0] UCP_BS    = 21'h08;
    localparam logic [20:0] UCP_LF    = 21'h0A;
    localparam logic [20:0] UCP_FF    = 21'h0C;
    localparam logic [20:0] UCP_CR    = 21'h0D;
    localparam logic [20:0] UCP_SPACE = 21'h20;

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StNewline,
        StClear
    } state_e;

    // Advance a row address by one row, wrapping TOTAL back to 0.
    function automatic logic [ADDRW-1:0] next_row(input logic [ADDRW-1:0] base);
        logic [ADDRW:0] sum;
        sum = {1'b0, base} + {1'b0, HRES_W};
        if (sum >= TOTAL_X) begin
            sum = sum - TOTAL_X;
        end
        return sum[ADDRW-1:0];
    endfunction

    function automatic logic [WORD-1:0] pack_word(input logic [CIDXW-1:0] bg,
                                                  input logic [CIDXW-1:0] fg,
                                                  input logic [20:0]      ucp);
        logic [WORD-1:0] w;
        w                        = '0;
        w[WORD-1 -: CIDXW]       = bg;
        w[WORD-CIDXW-1 -: CIDXW] = fg;
        w[20:0]                  = ucp;
        return w;
    endfunction

    state_e           r_state,     w_state;
    logic [20:0]      r_ucp,       w_ucp;
    logic [CIDXW-1:0] r_fg,        w_fg;
    logic [CIDXW-1:0] r_bg,        w_bg;
    logic [ADDRW-1:0] r_cur_x,     w_cur_x;
    logic [ADDRW-1:0] r_cur_y,     w_cur_y;
    logic [ADDRW-1:0] r_row_base,  w_row_base;
    logic [ADDRW-1:0] r_scroll,    w_scroll;
    logic [ADDRW-1:0] r_clr_addr,  w_clr_addr;
    logic [ADDRW-1:0] r_clr_left,  w_clr_left;   // words remaining minus one
    logic             r_cls,       w_cls;        // current clear is a full-screen clear
    logic             r_cmd_ready, w_cmd_ready;
    logic             r_tram_we,   w_tram_we;
    logic [ADDRW-1:0] r_tram_addr, w_tram_addr;
    logic [WORD-1:0]  r_tram_din,  w_tram_din;
    logic             r_busy,      w_busy;

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            r_state     <= StIdle;
            r_ucp       <= '0;
            r_fg        <= '0;
            r_bg        <= '0;
            r_cur_x     <= '0;
            r_cur_y     <= '0;
            r_row_base  <= '0;
            r_scroll    <= '0;
            r_clr_addr  <= '0;
            r_clr_left  <= '0;
            r_cls       <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_tram_we   <= 1'b0;
            r_tram_addr <= '0;
            r_tram_din  <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_ucp       <= w_ucp;
            r_fg        <= w_fg;
            r_bg        <= w_bg;
            r_cur_x     <= w_cur_x;
            r_cur_y     <= w_cur_y;
            r_row_base  <= w_row_base;
            r_scroll    <= w_scroll;
            r_clr_addr  <= w_clr_addr;
            r_clr_left  <= w_clr_left;
            r_cls       <= w_cls;
            r_cmd_ready <= w_cmd_ready;
            r_tram_we   <= w_tram_we;
            r_tram_addr <= w_tram_addr;
            r_tram_din  <= w_tram_din;
            r_busy      <= w_busy;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_ucp       = r_ucp;
        w_fg        = r_fg;
        w_bg        = r_bg;
        w_cur_x     = r_cur_x;
        w_cur_y     = r_cur_y;
        w_row_base  = r_row_base;
        w_scroll    = r_scroll;
        w_clr_addr  = r_clr_addr;
        w_clr_left  = r_clr_left;
        w_cls       = r_cls;
        w_cmd_ready = 1'b0;
        w_tram_we   = 1'b0;
        w_tram_addr = r_tram_addr;
        w_tram_din  = r_tram_din;
        w_busy      = 1'b0;

        unique case (r_state)
            StIdle: begin
                w_cmd_ready = 1'b1;
                // r_cmd_ready gates acceptance so nothing is taken in the
                // first cycle after reset release.
                if (cmd_valid && r_cmd_ready) begin
                    w_ucp = cmd_ucp;
                    w_fg  = cmd_fg;
                    w_bg  = cmd_bg;
                    case (cmd_ucp)
                        UCP_BS: begin
                            if (r_cur_x != '0) begin
                                w_cur_x = r_cur_x - 1'b1;
                            end
                        end
                        UCP_CR: begin
                            w_cur_x = '0;
                        end
                        UCP_LF: begin
                            w_cur_x     = '0;
                            w_state     = StNewline;
                            w_cmd_ready = 1'b0;
                        end
                        UCP_FF: begin
`ifdef TEXT_CONSOLE_CLS_EN
                            w_clr_addr  = '0;
                            w_clr_left  = TOTAL_M1;
                            w_cls       = 1'b1;
                            w_busy      = 1'b1;
                            w_state     = StClear;
                            w_cmd_ready = 1'b0;
`else
                            // Form feed is swallowed when screen clear is not built.
                            w_cur_x = r_cur_x;
`endif
                        end
                        default: begin
                            w_state     = StWrite;
                            w_cmd_ready = 1'b0;
                        end
                    endcase
                end
            end

            StWrite: begin
                w_tram_we   = 1'b1;
                w_tram_addr = r_row_base + r_cur_x;
                w_tram_din  = pack_word(r_bg, r_fg, r_ucp);
                if (r_cur_x == HRES_M1) begin
                    w_cur_x = '0;
                    w_state = StNewline;
                end else begin
                    w_cur_x     = r_cur_x + 1'b1;
                    w_state     = StIdle;
                    w_cmd_ready = 1'b1;
                end
            end

            StNewline: begin
                if (r_cur_y != VRES_M1) begin
                    w_cur_y     = r_cur_y + 1'b1;
                    w_row_base  = next_row(r_row_base);
                    w_state     = StIdle;
                    w_cmd_ready = 1'b1;
                end else begin
                    // The old top row becomes the new bottom row and is blanked.
                    w_scroll   = next_row(r_scroll);
                    w_row_base = r_scroll;
                    w_clr_addr = r_scroll;
                    w_clr_left = HRES_M1;
                    w_cls      = 1'b0;
                    w_busy     = 1'b1;
                    w_state    = StClear;
                end
            end

            StClear: begin
                w_busy      = 1'b1;
                w_tram_we   = 1'b1;
                w_tram_addr = r_clr_addr;
                w_tram_din  = pack_word(r_bg, r_fg, UCP_SPACE);
                w_clr_addr  = r_clr_addr + 1'b1;
                w_clr_left  = r_clr_left - 1'b1;
                if (r_clr_left == '0) begin
                    w_busy      = 1'b0;
                    w_state     = StIdle;
                    w_cmd_ready = 1'b1;
                    w_clr_left  = '0;
                    if (r_cls) begin
                        w_scroll   = '0;
                        w_row_base = '0;
                        w_cur_x    = '0;
                        w_cur_y    = '0;
                        w_cls      = 1'b0;
                    end
                end
            end

            default: begin
                w_state = StIdle;
            end
        endcase
    end

    assign cmd_ready   = r_cmd_ready;
    assign tram_we     = r_tram_we;
    assign tram_addr   = r_tram_addr;
    assign tram_din    = r_tram_din;
    assign scroll_offs = r_scroll;
    assign cur_x       = r_cur_x;
    assign cur_y       = r_cur_y;
    assign busy        = r_busy;

endmodule

// File: tb/tb_text_console.sv
// ----------------------------------------------------------------------------
// tb_text_console
//   Self-checking bench for text_console in its default build (form feed
//   swallowed). Table-driven single-command vectors plus hand-written
//   sequences for line wrap, scrolling, hold-off during clear, scroll wrap
//   and reset in the middle of a clear.
// ----------------------------------------------------------------------------
module tb_text_console;

    localparam int unsigned WORD  = 32;
    localparam int unsigned ADDRW = 14;
    localparam int unsigned CIDXW = 4;
    localparam int unsigned HRES  = 84;
    localparam int unsigned VRES  = 24;

    logic             clk_sys   = 1'b0;
    logic             rst_sys_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [20:0]      cmd_ucp   = '0;
    logic [CIDXW-1:0] cmd_fg    = '0;
    logic [CIDXW-1:0] cmd_bg    = '0;
    logic             tram_we;
    logic [ADDRW-1:0] tram_addr;
    logic [WORD-1:0]  tram_din;
    logic [ADDRW-1:0] scroll_offs;
    logic [ADDRW-1:0] cur_x;
    logic [ADDRW-1:0] cur_y;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    text_console #(
        .WORD      (WORD),
        .ADDRW     (ADDRW),
        .CIDXW     (CIDXW),
        .TRAM_HRES (HRES),
        .TRAM_VRES (VRES)
    ) dut (
        .clk_sys     (clk_sys),
        .rst_sys_n   (rst_sys_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_ucp     (cmd_ucp),
        .cmd_fg      (cmd_fg),
        .cmd_bg      (cmd_bg),
        .tram_we     (tram_we),
        .tram_addr   (tram_addr),
        .tram_din    (tram_din),
        .scroll_offs (scroll_offs),
        .cur_x       (cur_x),
        .cur_y       (cur_y),
        .busy        (busy)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [20:0] ucp;
        logic [3:0]  fg;
        logic [3:0]  bg;
        logic        rdy0;   // cmd_ready just after the accept edge
        logic        we;     // tram_we one edge later
        logic [13:0] addr;
        logic [31:0] din;
        logic [13:0] cx;
        logic [13:0] cy;
    } vec_t;

    vec_t tv[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Waits for cmd_ready at a falling edge, presents one command and returns
    // 1 ns after the accepting rising edge with cmd_valid dropped.
    task automatic send(input logic [20:0] ucp, input logic [3:0] fg, input logic [3:0] bg);
        int n;
        n = 0;
        @(negedge clk_sys);
        while (!cmd_ready && n < 5000) begin
            @(negedge clk_sys);
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: cmd_ready=0 expected 1");
        end
        cmd_valid = 1'b1;
        cmd_ucp   = ucp;
        cmd_fg    = fg;
        cmd_bg    = bg;
        @(posedge clk_sys);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0;
        rst_sys_n = 1'b0;
        #3;
        chk("rst_ready",  32'(cmd_ready),   32'd0);
        chk("rst_we",     32'(tram_we),     32'd0);
        chk("rst_addr",   32'(tram_addr),   32'd0);
        chk("rst_din",    32'(tram_din),    32'd0);
        chk("rst_scroll", 32'(scroll_offs), 32'd0);
        chk("rst_cur_x",  32'(cur_x),       32'd0);
        chk("rst_cur_y",  32'(cur_y),       32'd0);
        chk("rst_busy",   32'(busy),        32'd0);
        @(negedge clk_sys);
        rst_sys_n = 1'b1;
        #1;
        chk("ready_before_first_edge", 32'(cmd_ready), 32'd0);
        @(posedge clk_sys);
        #1;
        chk("ready_after_first_edge", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int busy_cyc;
        int wr;
        int abad;
        int dbad;
        int rdy_bad;
        bit done;

        //             ucp        fg     bg     rdy0  we    addr    din            cx     cy
        tv[0]  = '{21'h41,     4'h7, 4'h2, 1'b0, 1'b1, 14'd0,  32'h2700_0041, 14'd1, 14'd0};
        tv[1]  = '{21'h42,     4'h3, 4'h5, 1'b0, 1'b1, 14'd1,  32'h5300_0042, 14'd2, 14'd0};
        tv[2]  = '{21'h08,     4'h0, 4'h0, 1'b1, 1'b0, 14'd0,  32'h0,         14'd1, 14'd0};
        tv[3]  = '{21'h43,     4'hF, 4'h0, 1'b0, 1'b1, 14'd1,  32'h0F00_0043, 14'd2, 14'd0};
        tv[4]  = '{21'h0D,     4'h0, 4'h0, 1'b1, 1'b0, 14'd0,  32'h0,         14'd0, 14'd0};
        tv[5]  = '{21'h0A,     4'h0, 4'h0, 1'b0, 1'b0, 14'd0,  32'h0,         14'd0, 14'd1};
        tv[6]  = '{21'h44,     4'h1, 4'h1, 1'b0, 1'b1, 14'd84, 32'h1100_0044, 14'd1, 14'd1};
        tv[7]  = '{21'h0C,     4'h0, 4'h0, 1'b1, 1'b0, 14'd0,  32'h0,         14'd1, 14'd1};
        tv[8]  = '{21'h08,     4'h0, 4'h0, 1'b1, 1'b0, 14'd0,  32'h0,         14'd0, 14'd1};
        tv[9]  = '{21'h08,     4'h0, 4'h0, 1'b1, 1'b0, 14'd0,  32'h0,         14'd0, 14'd1};
        tv[10] = '{21'h1F600,  4'hA, 4'hB, 1'b0, 1'b1, 14'd84, 32'hBA01_F600, 14'd1, 14'd1};
        tv[11] = '{21'h10FFFF, 4'h0, 4'hF, 1'b0, 1'b1, 14'd85, 32'hF010_FFFF, 14'd2, 14'd1};

        do_reset();

        for (int i = 0; i < 12; i++) begin
            send(tv[i].ucp, tv[i].fg, tv[i].bg);
            chk($sformatf("v%0d_ready_after_accept", i), 32'(cmd_ready), 32'(tv[i].rdy0));
            @(posedge clk_sys);
            #1;
            chk($sformatf("v%0d_we", i), 32'(tram_we), 32'(tv[i].we));
            if (tv[i].we) begin
                chk($sformatf("v%0d_addr", i), 32'(tram_addr), 32'(tv[i].addr));
                chk($sformatf("v%0d_din", i), tram_din, tv[i].din);
            end
            chk($sformatf("v%0d_cur_x", i), 32'(cur_x), 32'(tv[i].cx));
            chk($sformatf("v%0d_cur_y", i), 32'(cur_y), 32'(tv[i].cy));
            chk($sformatf("v%0d_ready_next", i), 32'(cmd_ready), 32'd1);
        end

        // Line wrap: 85 printables from (0,0); write i lands at address i.
        do_reset();
        bad = 0;
        for (int i = 0; i < 85; i++) begin
            send(21'h61 + 21'(i % 26), 4'd1, 4'd0);
            @(posedge clk_sys);
            #1;
            if (!tram_we || tram_addr != 14'(i)) bad++;
        end
        chk("wrap_addr_seq", 32'(bad), 32'd0);
        chk("wrap_last_addr", 32'(tram_addr), 32'd84);
        chk("wrap_cur_x", 32'(cur_x), 32'd1);
        chk("wrap_cur_y", 32'(cur_y), 32'd1);

        // Walk the cursor down to the bottom row.
        send(21'h0D, 4'd0, 4'd0);
        for (int i = 0; i < 22; i++) begin
            send(21'h0A, 4'd0, 4'd0);
        end
        @(posedge clk_sys);
        #1;
        chk("bottom_cur_y", 32'(cur_y), 32'd23);
        chk("bottom_scroll", 32'(scroll_offs), 32'd0);

        // Scroll with bg=1 while a 'Z' is held valid for the whole clear.
        send(21'h0A, 4'd0, 4'd1);
        cmd_valid = 1'b1;
        cmd_ucp   = 21'h5A;
        cmd_fg    = 4'd2;
        cmd_bg    = 4'd3;
        @(posedge clk_sys);
        #1;
        chk("scroll_offs_84", 32'(scroll_offs), 32'd84);
        chk("scroll_busy_start", 32'(busy), 32'd1);
        busy_cyc = 0;
        wr       = 0;
        abad     = 0;
        dbad     = 0;
        rdy_bad  = 0;
        done     = 1'b0;
        for (int k = 0; k < 300 && !done; k++) begin
            if (busy) busy_cyc++;
            if (busy && cmd_ready) rdy_bad++;
            if (tram_we) begin
                if (tram_addr != 14'(wr)) abad++;
                if (tram_din != 32'h1000_0020) dbad++;
                wr++;
            end
            if (!busy && !tram_we) begin
                done = 1'b1;
            end else begin
                @(posedge clk_sys);
                #1;
            end
        end
        cmd_valid = 1'b0;
        chk("clear_finished", 32'(done), 32'd1);
        chk("clear_busy_cycles", 32'(busy_cyc), 32'd84);
        chk("clear_write_count", 32'(wr), 32'd84);
        chk("clear_addr_errors", 32'(abad), 32'd0);
        chk("clear_din_errors", 32'(dbad), 32'd0);
        chk("clear_ready_while_busy", 32'(rdy_bad), 32'd0);
        chk("clear_cur_y", 32'(cur_y), 32'd23);
        chk("clear_cur_x", 32'(cur_x), 32'd0);
        @(posedge clk_sys);
        #1;
        chk("held_cmd_we", 32'(tram_we), 32'd1);
        chk("held_cmd_addr", 32'(tram_addr), 32'd0);
        chk("held_cmd_din", tram_din, 32'h3200_005A);
        chk("held_cmd_cur_x", 32'(cur_x), 32'd1);

        // 23 more scrolls bring scroll_offs round to 0 (24 * 84 = 2016).
        for (int j = 0; j < 23; j++) begin
            send(21'h0A, 4'd0, 4'd0);
            if (j == 0) begin
                @(posedge clk_sys);
                #1;
                chk("scroll_offs_168", 32'(scroll_offs), 32'd168);
            end
        end
        send(21'h08, 4'd0, 4'd0);
        chk("scroll_wrap_zero", 32'(scroll_offs), 32'd0);
        chk("scroll_wrap_cur_y", 32'(cur_y), 32'd23);
        chk("bs_at_col0_cur_x", 32'(cur_x), 32'd0);

        // Reset in the middle of a row clear.
        send(21'h0A, 4'd0, 4'hE);
        repeat (10) @(posedge clk_sys);
        #2;
        chk("midclear_busy", 32'(busy), 32'd1);
        chk("midclear_we", 32'(tram_we), 32'd1);
        rst_sys_n = 1'b0;
        #1;
        chk("abort_we", 32'(tram_we), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_scroll", 32'(scroll_offs), 32'd0);
        chk("abort_cur_x", 32'(cur_x), 32'd0);
        chk("abort_cur_y", 32'(cur_y), 32'd0);
        @(negedge clk_sys);
        rst_sys_n = 1'b1;
        @(posedge clk_sys);
        #1;
        chk("abort_ready", 32'(cmd_ready), 32'd1);
        send(21'h51, 4'd4, 4'd6);
        @(posedge clk_sys);
        #1;
        chk("post_abort_addr", 32'(tram_addr), 32'd0);
        chk("post_abort_din", tram_din, 32'h6400_0051);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
